// File: rtl/encoder_pkg.sv
// Shared parameters, the stage-1 group-result type and helpers for encoder_32_pipe.
// Also used by the ENCODER_ONEHOT_CHECK_EN multi-hot flag path.
package encoder_pkg;

    localparam int REQ_W      = 32;
    localparam int IDX_W      = 5;
    localparam int GROUP_W    = 4;
    localparam int NUM_GROUPS = 8;
    localparam int GSEL_W     = 3;

    typedef struct packed {
        logic       hit;
        logic [1:0] idx;
    } grp_res_t;

    // True when two or more bits are set: clearing the lowest set bit leaves something behind.
    function automatic logic multi_hot(input logic [REQ_W-1:0] v);
        return (v & (v - 32'd1)) != 32'd0;
    endfunction

endpackage

// File: rtl/encoder_32_pipe_if.sv
// Request/result handshake bundle for encoder_32_pipe.
// out_multi exists only when ENCODER_ONEHOT_CHECK_EN is defined.
interface encoder_32_pipe_if;
    import encoder_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [REQ_W-1:0]  in_req;
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_idx;
    logic              out_none;
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic              out_multi;
`endif

    modport master (
        output in_valid, in_req, out_ready,
        input  in_ready, out_valid, out_idx, out_none
`ifdef ENCODER_ONEHOT_CHECK_EN
        , input out_multi
`endif
    );

    modport slave (
        input  in_valid, in_req, out_ready,
        output in_ready, out_valid, out_idx, out_none
`ifdef ENCODER_ONEHOT_CHECK_EN
        , output out_multi
`endif
    );

endinterface

// File: rtl/encoder_4.sv
// Combinational 4:2 priority encoder, bit 0 wins, with a group-hit flag.
module encoder_4
    import encoder_pkg::*;
(
    input  logic [GROUP_W-1:0] req,
    output grp_res_t           res
);

    // Lowest set bit of the group selects the index.
    always_comb begin
        res = '{hit: 1'b0, idx: 2'd0};
        casez (req)
            4'b???1: res = '{hit: 1'b1, idx: 2'd0};
            4'b??10: res = '{hit: 1'b1, idx: 2'd1};
            4'b?100: res = '{hit: 1'b1, idx: 2'd2};
            4'b1000: res = '{hit: 1'b1, idx: 2'd3};
            default: res = '{hit: 1'b0, idx: 2'd0};
        endcase
    end

endmodule

// File: rtl/encoder_32_pipe.sv
// Two-stage 32-bit lowest-set-bit priority encoder with valid/ready flow control.
// Define ENCODER_ONEHOT_CHECK_EN to add the pipelined out_multi flag.
module encoder_32_pipe
    import encoder_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    encoder_32_pipe_if.slave     bus
);

    grp_res_t          grp_s [NUM_GROUPS];
    grp_res_t          grp_d [NUM_GROUPS];
    grp_res_t          grp_q [NUM_GROUPS];
    logic              s1_valid_d, s1_valid_q;
    logic              s2_valid_d, s2_valid_q;
    logic [IDX_W-1:0]  out_idx_d, out_idx_q;
    logic              out_none_d, out_none_q;
    logic [IDX_W-1:0]  sel_idx_s;
    logic              sel_none_s;
    logic              s2_drain_s, s1_adv_s, in_ready_s, in_fire_s;
`ifdef ENCODER_ONEHOT_CHECK_EN
    logic              multi_s1_d, multi_s1_q;
    logic              out_multi_d, out_multi_q;
`endif

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_enc
        encoder_4 u_enc (
            .req (bus.in_req[g*GROUP_W +: GROUP_W]),
            .res (grp_s[g])
        );
    end

    // Flow control: S2 frees when empty or consumed; in_ready held low while in reset.
    always_comb begin
        s2_drain_s = !s2_valid_q || bus.out_ready;
        s1_adv_s   = s1_valid_q && s2_drain_s;
        in_ready_s = reset_n && (!s1_valid_q || s2_drain_s);
        in_fire_s  = bus.in_valid && in_ready_s;
    end

    // Stage-1 next state: capture group results on accept, empty when advanced.
    always_comb begin
        s1_valid_d = s1_valid_q;
        grp_d      = grp_q;
`ifdef ENCODER_ONEHOT_CHECK_EN
        multi_s1_d = multi_s1_q;
`endif
        if (in_fire_s) begin
            s1_valid_d = 1'b1;
            grp_d      = grp_s;
`ifdef ENCODER_ONEHOT_CHECK_EN
            multi_s1_d = multi_hot(bus.in_req);
`endif
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end
    end

    // Lowest hit group wins; scanning downward leaves the lowest one last.
    always_comb begin
        sel_idx_s  = '0;
        sel_none_s = 1'b1;
        for (int i = NUM_GROUPS - 1; i >= 0; i--) begin
            if (grp_q[i].hit) begin
                sel_idx_s  = {i[GSEL_W-1:0], grp_q[i].idx};
                sel_none_s = 1'b0;
            end else begin
                sel_idx_s  = sel_idx_s;
                sel_none_s = sel_none_s;
            end
        end
    end

    // Stage-2 next state: reload only when draining and S1 has data, otherwise hold.
    always_comb begin
        s2_valid_d  = s2_valid_q;
        out_idx_d   = out_idx_q;
        out_none_d  = out_none_q;
`ifdef ENCODER_ONEHOT_CHECK_EN
        out_multi_d = out_multi_q;
`endif
        if (s1_adv_s) begin
            s2_valid_d  = 1'b1;
            out_idx_d   = sel_idx_s;
            out_none_d  = sel_none_s;
`ifdef ENCODER_ONEHOT_CHECK_EN
            out_multi_d = multi_s1_q;
`endif
        end else if (s2_drain_s) begin
            s2_valid_d  = 1'b0;
        end else begin
            s2_valid_d  = s2_valid_q;
        end
    end

    // Pipeline registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            out_idx_q   <= '0;
            out_none_q  <= 1'b0;
            for (int i = 0; i < NUM_GROUPS; i++) begin
                grp_q[i] <= '{hit: 1'b0, idx: 2'd0};
            end
`ifdef ENCODER_ONEHOT_CHECK_EN
            multi_s1_q  <= 1'b0;
            out_multi_q <= 1'b0;
`endif
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            out_idx_q   <= out_idx_d;
            out_none_q  <= out_none_d;
            grp_q       <= grp_d;
`ifdef ENCODER_ONEHOT_CHECK_EN
            multi_s1_q  <= multi_s1_d;
            out_multi_q <= out_multi_d;
`endif
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = s2_valid_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_none  = out_none_q;
`ifdef ENCODER_ONEHOT_CHECK_EN
    assign bus.out_multi = out_multi_q;
`endif

endmodule

// File: tb/tb_encoder_32_pipe.sv
// Scoreboard bench for encoder_32_pipe: directed corner cases plus random traffic with backpressure.
module tb_encoder_32_pipe;
    import encoder_pkg::*;

    typedef struct packed {
        logic [4:0] idx;
        logic       none;
        logic       multi;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    encoder_32_pipe_if bus ();

    encoder_32_pipe dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    exp_t       sb_q[$];
    int         checks = 0;
    int         failures = 0;
    int         acc_cnt = 0;
    int         pop_cnt = 0;
    logic       prev_stall = 1'b0;
    logic [4:0] prev_idx = 5'd0;
    logic       prev_none = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [31:0] v);
        exp_t e;
        e.idx   = 5'd0;
        e.none  = 1'b1;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) begin
                e.idx  = i[4:0];
                e.none = 1'b0;
            end
        end
        e.multi = ($countones(v) > 1);
        return e;
    endfunction

    // Monitor: pop/compare on output transfer, push expectation on input transfer.
    always @(negedge clk) begin
        if (!reset_n) begin
            sb_q.delete();
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall) begin
                check_eq("stall_valid", bus.out_valid, 1'b1);
                check_eq("stall_idx", bus.out_idx, prev_idx);
                check_eq("stall_none", bus.out_none, prev_none);
            end
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check_eq("unexpected_output", bus.out_valid, 1'b0);
                end else begin
                    check_eq("sb_idx", bus.out_idx, sb_q[0].idx);
                    check_eq("sb_none", bus.out_none, sb_q[0].none);
`ifdef ENCODER_ONEHOT_CHECK_EN
                    check_eq("sb_multi", bus.out_multi, sb_q[0].multi);
`endif
                    void'(sb_q.pop_front());
                    pop_cnt <= pop_cnt + 1;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                sb_q.push_back(model(bus.in_req));
                acc_cnt <= acc_cnt + 1;
            end
            prev_stall <= bus.out_valid && !bus.out_ready;
            prev_idx   <= bus.out_idx;
            prev_none  <= bus.out_none;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] r, input logic ordy);
        bus.in_valid  = v;
        bus.in_req    = r;
        bus.out_ready = ordy;
    endtask

    initial begin
        #1000000;
        $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

    initial begin
        int a0, p0, guard;
        logic [31:0] r;
        drive(1'b0, 32'h0, 1'b0);
        reset_n = 1'b0;
        repeat (3) step();
        @(negedge clk);
        check_eq("rst_in_ready", bus.in_ready, 1'b0);
        check_eq("rst_out_valid", bus.out_valid, 1'b0);
        check_eq("rst_out_idx", bus.out_idx, 5'd0);
        check_eq("rst_out_none", bus.out_none, 1'b0);
`ifdef ENCODER_ONEHOT_CHECK_EN
        check_eq("rst_out_multi", bus.out_multi, 1'b0);
`endif
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("post_rst_in_ready", bus.in_ready, 1'b1);

        // Two-cycle latency for a single vector
        step();
        drive(1'b1, 32'h0000_0001, 1'b1);
        @(negedge clk);
        check_eq("lat_in_ready", bus.in_ready, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_eq("lat_c1_valid", bus.out_valid, 1'b0);
        step();
        @(negedge clk);
        check_eq("lat_c2_valid", bus.out_valid, 1'b1);
        check_eq("lat_c2_idx", bus.out_idx, 5'd0);
        check_eq("lat_c2_none", bus.out_none, 1'b0);

        // Back-to-back vectors emerge on consecutive cycles
        step();
        drive(1'b1, 32'h8000_0000, 1'b1);
        step();
        drive(1'b1, 32'h0001_0100, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_eq("b2b_first_valid", bus.out_valid, 1'b1);
        check_eq("b2b_first_idx", bus.out_idx, 5'd31);
        step();
        @(negedge clk);
        check_eq("b2b_second_valid", bus.out_valid, 1'b1);
        check_eq("b2b_second_idx", bus.out_idx, 5'd8);

        // Zero vector, then a two-hot vector
        step();
        drive(1'b1, 32'h0, 1'b1);
        step();
        drive(1'b1, 32'h0000_0003, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_eq("zero_none", bus.out_none, 1'b1);
        check_eq("zero_idx", bus.out_idx, 5'd0);
        step();
        @(negedge clk);
        check_eq("two_hot_idx", bus.out_idx, 5'd0);
        check_eq("two_hot_none", bus.out_none, 1'b0);
`ifdef ENCODER_ONEHOT_CHECK_EN
        check_eq("two_hot_multi", bus.out_multi, 1'b1);
`endif

        // Backpressure: only two vectors fit, outputs hold, release drains in order
        step();
        a0 = acc_cnt;
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 32'h1 << (k + 4), 1'b0);
            step();
        end
        check_eq("stall_accepted", acc_cnt - a0, 2);
        @(negedge clk);
        check_eq("stall_in_ready", bus.in_ready, 1'b0);
        check_eq("stall_out_idx", bus.out_idx, 5'd4);
        step();
        drive(1'b0, 32'h0, 1'b1);
        @(negedge clk);
        check_eq("release_first", bus.out_idx, 5'd4);
        step();
        @(negedge clk);
        check_eq("release_second_valid", bus.out_valid, 1'b1);
        check_eq("release_second", bus.out_idx, 5'd5);

        // Reset with two vectors in flight
        step();
        drive(1'b1, 32'h0000_0100, 1'b0);
        step();
        drive(1'b1, 32'h0000_0200, 1'b0);
        step();
        drive(1'b0, 32'h0, 1'b0);
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check_eq("midrst_out_valid", bus.out_valid, 1'b0);
        check_eq("midrst_in_ready", bus.in_ready, 1'b1);
        step();
        drive(1'b0, 32'h0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check_eq("midrst_no_stale", bus.out_valid, 1'b0);
            step();
        end

        // Random traffic with random backpressure
        a0 = acc_cnt;
        p0 = pop_cnt;
        for (int n = 0; n < 10000; n++) begin
            case ($urandom_range(0, 3))
                0: r = 32'h0;
                1: r = 32'h1 << $urandom_range(0, 31);
                2: r = $urandom() & $urandom() & $urandom();
                default: r = $urandom();
            endcase
            drive($urandom_range(0, 3) != 0, r, $urandom_range(0, 3) != 0);
            step();
        end
        drive(1'b0, 32'h0, 1'b1);
        guard = 0;
        while (sb_q.size() != 0 && guard < 20) begin
            step();
            guard++;
        end
        step();
        check_eq("drain_empty", sb_q.size(), 0);
        check_eq("zero_loss", pop_cnt - p0, acc_cnt - a0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
